conv_scheduler: RTL and testbench
=================================

# conv_scheduler

Sequencer for the double-precision convolution datapath: accepts a job (signal length `len1`, kernel length `len2`), splits the valid-convolution outputs across `NUM_FPUS` FPU MAC lanes, and issues one `(x1 index, x2 index)` multiply-accumulate operation per lane per cycle under a valid/ready handshake. It counts lane write-backs and signals completion. It sits between the job control logic and the FPU lane array / x1, x2, y storage.

## Interface
- `NUM_FPUS`, 4: number of MAC lanes (1..16).
- `LEN_W`, 8: width of length and index fields.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `len1`  in  LEN_W  signal length; sampled with `start`.
- `len2`  in  LEN_W  kernel length; sampled with `start`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse: rejected job.
- `issue_valid`  out  NUM_FPUS  per-lane MAC op valid.
- `issue_ready`  in  NUM_FPUS  per-lane accept.
- `issue_x1_idx`  out  NUM_FPUS*LEN_W  x1 element index, lane l at `[l*LEN_W +: LEN_W]`.
- `issue_x2_idx`  out  NUM_FPUS*LEN_W  x2 element index, same packing.
- `issue_out_idx`  out  NUM_FPUS*LEN_W  y index being accumulated.
- `issue_first`  out  NUM_FPUS  op is first of an output; lane clears accumulator.
- `issue_last`  out  NUM_FPUS  op is last of an output; lane writes y after its pipeline.
- `wb_valid`  in  NUM_FPUS  lane reports one y element written (one-cycle pulse per output).

## Operation
- `out_len = len1 - len2 + 1`; computed in LEN_W+1 bits. Job valid iff `len2 != 0` and `len2 <= len1`.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `start` with valid lengths -> latch lengths, initialise lanes, go RUN. `start` with invalid lengths -> `err`=1 for one cycle, stay IDLE. `start` outside IDLE is ignored (no `err`).
- Lane l owns outputs `l, l+NUM_FPUS, l+2*NUM_FPUS, ...` below `out_len`. Lanes with `l >= out_len` are finished from the start and never assert `issue_valid`.
- Per lane registers: `out` index, `k` counter. Op payload: `x1_idx = out + k`, `x2_idx = k`, `out_idx = out`, `first = (k == 0)`, `last = (k == len2-1)`.
- A handshake (`valid && ready`) advances the lane: `k++`; if `last`, then `k=0` and `out += NUM_FPUS`. If the new `out >= out_len`, the lane finishes and drops `issue_valid`.
- Valid/ready rule: while `issue_valid` is high and `ready` is low, payload holds stable. Valid never drops without a handshake except on reset.
- RUN -> DRAIN when every lane has finished issuing, including a same-cycle final handshake.
- Write-back counter (LEN_W+1 bits) adds popcount(`wb_valid`) each cycle in RUN and DRAIN. `wb_valid` is ignored in IDLE and DONE.
- DRAIN -> DONE when the counter equals `out_len`; this can also occur in RUN if write-backs overtake. DONE lasts one cycle with `done`=1, then returns to IDLE.
- Every ordered pair `(out, k)` is issued exactly once. Total issues = `out_len*len2`.
- `reset` in any state: return to IDLE, clear all counters, no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `issue_valid`=0, all index outputs 0, `issue_first`=0, `issue_last`=0.
- `start` accepted at edge t -> `busy` and the first `issue_valid` (with `first`=1) high in cycle t+1.
- Throughput: one op per lane per cycle under continuous `ready`.
- All outputs are driven from registers or lane state. There is no combinational path from `issue_ready` or `wb_valid` to any output.
- `busy` is high from t+1 through the DONE cycle inclusive. It is low in the cycle after `done`. A new `start` is accepted in that cycle.
- `err` asserts the cycle after the rejected `start`.

## Structure
- Package `conv_pkg`: `LEN_W` default, state enum `conv_state_t` {IDLE, RUN, DRAIN, DONE}, index typedef `conv_idx_t`.
- Sub-module `conv_lane_seq`, instantiated NUM_FPUS times. It holds `out`/`k`, generates the payload and the finished flag, and takes lane id, `out_len`, `len2` and an init strobe. The top level holds the FSM, the write-back counter and the popcount.

## Test plan
- len1=10, len2=3, all ready=1, wb_valid pulsed 4 cycles after each `last`: out_len=8, 24 issues. Lane0 issues out 0 then out 4 (x1_idx 0,1,2,4,5,6). `done` fires once after 8 write-backs. `busy` is high from t+1.
- len1=5, len2=5: out_len=1. Only lane0 issues 5 ops (first at k=0, last at k=4). Lanes 1-3 never valid. `done` follows the single wb.
- len2=0 and len2=6 with len1=5: `err` pulse at t+1, `busy` stays 0, no issues.
- Random `issue_ready` backpressure on len1=20, len2=4: payload stable while stalled. 68 unique (out,k) pairs, no duplicates or gaps.
- `start` pulsed during RUN: ignored, job unaffected. `reset` asserted mid-RUN: all outputs at reset values next cycle. A fresh job then completes normally.
- Back-to-back jobs: `start` in the cycle after `done` is accepted.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution scheduler slice.
package conv_pkg;

   localparam int unsigned CONV_LEN_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} conv_state_t;

   typedef logic [CONV_LEN_W-1:0] conv_idx_t;

   // Covers up to 16 lanes; callers zero-extend narrower vectors.
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/conv_scheduler_if.sv
// Issue and write-back bus between the scheduler and the FPU lane array.
interface conv_scheduler_if #(
   parameter int unsigned NUM_FPUS = 4,
   parameter int unsigned LEN_W    = 8
) ();

   logic [NUM_FPUS-1:0]       issue_valid;
   logic [NUM_FPUS-1:0]       issue_ready;
   logic [NUM_FPUS*LEN_W-1:0] issue_x1_idx;
   logic [NUM_FPUS*LEN_W-1:0] issue_x2_idx;
   logic [NUM_FPUS*LEN_W-1:0] issue_out_idx;
   logic [NUM_FPUS-1:0]       issue_first;
   logic [NUM_FPUS-1:0]       issue_last;
   logic [NUM_FPUS-1:0]       wb_valid;

   modport master (
      output issue_valid, issue_x1_idx, issue_x2_idx, issue_out_idx, issue_first, issue_last,
      input  issue_ready, wb_valid
   );

   modport slave (
      input  issue_valid, issue_x1_idx, issue_x2_idx, issue_out_idx, issue_first, issue_last,
      output issue_ready, wb_valid
   );

endinterface

// File: rtl/conv_lane_seq.sv
// Per-lane (out, k) walker: owns outputs lane_id, lane_id+NUM_FPUS, ... and emits one MAC op.
module conv_lane_seq #(
   parameter int unsigned NUM_FPUS = 4,
   parameter int unsigned LEN_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic [LEN_W-1:0] lane_id,
   input  logic [LEN_W:0]   out_len,
   input  logic [LEN_W-1:0] len2,
   input  logic             ready,
   output logic             valid,
   output logic [LEN_W-1:0] x1_idx,
   output logic [LEN_W-1:0] x2_idx,
   output logic [LEN_W-1:0] out_idx,
   output logic             first,
   output logic             last,
   output logic             finished_next
);

   logic [LEN_W:0]   out_q, out_d, out_step;
   logic [LEN_W-1:0] k_q, k_d;
   logic             valid_q, valid_d;
   logic             k_is_last, hs;

   assign k_is_last = (k_q == len2 - LEN_W'(1));
   assign out_step  = out_q + (LEN_W+1)'(NUM_FPUS);
   assign hs        = valid_q & ready;

   always_comb begin
      out_d   = out_q;
      k_d     = k_q;
      valid_d = valid_q;
      if (init) begin
         out_d   = {1'b0, lane_id};
         k_d     = '0;
         valid_d = ({1'b0, lane_id} < out_len);
      end else if (hs) begin
         if (k_is_last) begin
            k_d     = '0;
            out_d   = out_step;
            valid_d = (out_step < out_len);
         end else begin
            k_d = k_q + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q   <= '0;
         k_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         k_q     <= k_d;
         valid_q <= valid_d;
      end
   end

   // Payload is forced to zero while idle so the bus rests at its reset values.
   assign valid         = valid_q;
   assign x1_idx        = valid_q ? (out_q[LEN_W-1:0] + k_q) : '0;
   assign x2_idx        = valid_q ? k_q : '0;
   assign out_idx       = valid_q ? out_q[LEN_W-1:0] : '0;
   assign first         = valid_q && (k_q == '0);
   assign last          = valid_q && k_is_last;
   assign finished_next = ~valid_d;

endmodule

// File: rtl/conv_scheduler.sv
// Convolution job sequencer: splits outputs across MAC lanes and counts lane write-backs.
module conv_scheduler
   import conv_pkg::*;
#(
   parameter int unsigned NUM_FPUS = 4,
   parameter int unsigned LEN_W    = CONV_LEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len1,
   input  logic [LEN_W-1:0] len2,
   output logic             busy,
   output logic             done,
   output logic             err,
   conv_scheduler_if.master bus
);

   conv_state_t      state_q, state_d;
   logic [LEN_W:0]   out_len_q, out_len_d, job_out_len, lane_out_len;
   logic [LEN_W:0]   wb_cnt_q, wb_cnt_d, wb_sum;
   logic [LEN_W-1:0] len2_q, len2_d;
   logic             err_q, err_d;
   logic             init, job_ok, all_fin;
   logic [15:0]      wb_vec;
   logic [4:0]       wb_pop;

   logic [NUM_FPUS-1:0] fin_next;
   logic [NUM_FPUS-1:0] lane_valid, lane_first, lane_last;
   logic [LEN_W-1:0]    lane_x1  [NUM_FPUS];
   logic [LEN_W-1:0]    lane_x2  [NUM_FPUS];
   logic [LEN_W-1:0]    lane_out [NUM_FPUS];

   assign job_ok       = (len2 != '0) && (len2 <= len1);
   assign job_out_len  = {1'b0, len1} - {1'b0, len2} + (LEN_W+1)'(1);
   // Lanes need the new job's out_len on the init edge, before it is latched.
   assign lane_out_len = init ? job_out_len : out_len_q;
   assign wb_vec       = 16'(bus.wb_valid);
   assign wb_pop       = popcount16(wb_vec);
   assign wb_sum       = wb_cnt_q + (LEN_W+1)'(wb_pop);
   assign all_fin      = &fin_next;

   always_comb begin
      state_d   = state_q;
      out_len_d = out_len_q;
      len2_d    = len2_q;
      wb_cnt_d  = wb_cnt_q;
      err_d     = 1'b0;
      init      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (job_ok) begin
                  init      = 1'b1;
                  out_len_d = job_out_len;
                  len2_d    = len2;
                  wb_cnt_d  = '0;
                  state_d   = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            wb_cnt_d = wb_sum;
            if (wb_sum == out_len_q) begin
               state_d = DONE;
            end else if (all_fin) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            wb_cnt_d = wb_sum;
            if (wb_sum == out_len_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         out_len_q <= '0;
         len2_q    <= '0;
         wb_cnt_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_len_q <= out_len_d;
         len2_q    <= len2_d;
         wb_cnt_q  <= wb_cnt_d;
         err_q     <= err_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign err  = err_q;

   for (genvar l = 0; l < NUM_FPUS; l++) begin : g_lane
      conv_lane_seq #(
         .NUM_FPUS (NUM_FPUS),
         .LEN_W    (LEN_W)
      ) u_lane (
         .clk           (clk),
         .reset         (reset),
         .init          (init),
         .lane_id       (LEN_W'(l)),
         .out_len       (lane_out_len),
         .len2          (len2_q),
         .ready         (bus.issue_ready[l]),
         .valid         (lane_valid[l]),
         .x1_idx        (lane_x1[l]),
         .x2_idx        (lane_x2[l]),
         .out_idx       (lane_out[l]),
         .first         (lane_first[l]),
         .last          (lane_last[l]),
         .finished_next (fin_next[l])
      );
   end

   assign bus.issue_valid = lane_valid;
   assign bus.issue_first = lane_first;
   assign bus.issue_last  = lane_last;

   always_comb begin
      bus.issue_x1_idx  = '0;
      bus.issue_x2_idx  = '0;
      bus.issue_out_idx = '0;
      for (int l = 0; l < NUM_FPUS; l++) begin
         bus.issue_x1_idx[l*LEN_W +: LEN_W]  = lane_x1[l];
         bus.issue_x2_idx[l*LEN_W +: LEN_W]  = lane_x2[l];
         bus.issue_out_idx[l*LEN_W +: LEN_W] = lane_out[l];
      end
   end

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler: expected ops per lane are queued, a monitor pops on handshakes.
module tb_conv_scheduler;
   import conv_pkg::*;

   localparam int unsigned NF = 4;
   localparam int unsigned LW = 8;

   typedef struct packed {
      logic [LW-1:0] x1;
      logic [LW-1:0] x2;
      logic [LW-1:0] out;
      logic          first;
      logic          last;
   } op_t;

   logic      clk = 1'b0;
   logic      reset, start;
   conv_idx_t len1, len2;
   logic      busy, done, err;

   conv_scheduler_if #(.NUM_FPUS(NF), .LEN_W(LW)) bus ();

   conv_scheduler #(.NUM_FPUS(NF), .LEN_W(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .len1  (len1),
      .len2  (len2),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_pass   = 0;
   int  n_issues = 0;
   int  wb_total = 0;
   bit  rand_ready = 1'b0;
   op_t exp_q [NF][$];
   int  exp_done_q [$];
   bit  stalled [NF];
   op_t held [NF];

   task automatic check(input string name, input bit ok, input longint act, input longint exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_eq(input string name, input longint act, input longint exp);
      check(name, act == exp, act, exp);
   endtask

   function automatic op_t cur_op(input int l);
      op_t o;
      o.x1    = bus.issue_x1_idx[l*LW +: LW];
      o.x2    = bus.issue_x2_idx[l*LW +: LW];
      o.out   = bus.issue_out_idx[l*LW +: LW];
      o.first = bus.issue_first[l];
      o.last  = bus.issue_last[l];
      return o;
   endfunction

   // Expected op order per lane: outputs l, l+NF, ...; each walks k = 0..len2-1.
   task automatic expect_job(input int l1, input int l2);
      int  ol;
      op_t e;
      ol = l1 - l2 + 1;
      for (int l = 0; l < NF; l++) begin
         exp_q[l].delete();
         for (int o = l; o < ol; o += NF) begin
            for (int k = 0; k < l2; k++) begin
               e.x1    = LW'(o + k);
               e.x2    = LW'(k);
               e.out   = LW'(o);
               e.first = (k == 0);
               e.last  = (k == l2 - 1);
               exp_q[l].push_back(e);
            end
         end
      end
      exp_done_q.push_back(ol);
   endtask

   // Monitor: compares payloads on handshakes, stall stability, and done against wb count.
   always @(negedge clk) begin
      op_t o, e;
      bit  v, r;
      int  d;
      if (reset) begin
         for (int l = 0; l < NF; l++) stalled[l] = 1'b0;
      end else begin
         for (int l = 0; l < NF; l++) begin
            v = bus.issue_valid[l];
            r = bus.issue_ready[l];
            o = cur_op(l);
            if (stalled[l]) begin
               check_eq("stall_valid_held", v, 1);
               check_eq("stall_payload_held", o, held[l]);
            end
            stalled[l] = 1'b0;
            if (v) begin
               check("issue_expected", exp_q[l].size() != 0, l, -1);
               if (r && exp_q[l].size() != 0) begin
                  e = exp_q[l].pop_front();
                  check_eq("issue_payload", o, e);
                  n_issues++;
               end else if (!r) begin
                  stalled[l] = 1'b1;
                  held[l]    = o;
               end
            end
         end
         if (done) begin
            check("done_expected", exp_done_q.size() != 0, done, 0);
            if (exp_done_q.size() != 0) begin
               d = exp_done_q.pop_front();
               check_eq("done_wb_count", wb_total, d);
               for (int l = 0; l < NF; l++) check_eq("done_ops_left", exp_q[l].size(), 0);
            end
         end
      end
   end

   // Lane model: ready pattern plus a write-back pulse ~4 cycles after each last op.
   initial begin
      logic [NF-1:0] pipe [4];
      logic [NF-1:0] hs_last;
      bit            rst_seen;
      for (int i = 0; i < 4; i++) pipe[i] = '0;
      bus.issue_ready = '0;
      bus.wb_valid    = '0;
      forever begin
         @(negedge clk);
         rst_seen = reset;
         hs_last  = reset ? '0 : (bus.issue_valid & bus.issue_ready & bus.issue_last);
         @(posedge clk);
         #1;
         if (rst_seen) begin
            for (int i = 0; i < 4; i++) pipe[i] = '0;
            hs_last = '0;
         end
         bus.wb_valid = pipe[3];
         pipe[3] = pipe[2];
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = hs_last;
         wb_total += $countones(bus.wb_valid);
         bus.issue_ready = rand_ready ? NF'($urandom) : '1;
      end
   end

   // Caller is at posedge+1; returns at posedge+1 of the cycle after done.
   task automatic run_job(input int l1, input int l2, input int exp_issues, input bit poke);
      bit seen;
      expect_job(l1, l2);
      n_issues = 0;
      wb_total = 0;
      start = 1'b1;
      len1  = LW'(l1);
      len2  = LW'(l2);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("busy_after_start", busy, 1);
      check_eq("lane0_valid_first", {bus.issue_valid[0], bus.issue_first[0]}, 2'b11);
      check_eq("no_err_valid_job", err, 0);
      seen = 1'b0;
      for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
         if (poke && cyc == 3) begin
            start = 1'b1;
            len1  = 8'd5;
            len2  = 8'd6;
            @(posedge clk);
            #1;
            start = 1'b0;
            check_eq("start_in_run_no_err", err, 0);
            check_eq("start_in_run_busy", busy, 1);
         end
         @(negedge clk);
         seen = done;
      end
      check_eq("done_seen", seen, 1);
      @(posedge clk);
      #1;
      check_eq("busy_after_done", busy, 0);
      check_eq("issue_count", n_issues, exp_issues);
   endtask

   task automatic run_err(input int l1, input int l2);
      start = 1'b1;
      len1  = LW'(l1);
      len2  = LW'(l2);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("err_pulse", err, 1);
      check_eq("err_busy_low", busy, 0);
      check_eq("err_no_issue", bus.issue_valid, 0);
      @(posedge clk);
      #1;
      check_eq("err_one_cycle", err, 0);
      check_eq("err_still_idle", busy, 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      len1  = '0;
      len2  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_valid", bus.issue_valid, 0);
      check_eq("rst_x1", bus.issue_x1_idx, 0);
      check_eq("rst_x2", bus.issue_x2_idx, 0);
      check_eq("rst_out", bus.issue_out_idx, 0);
      check_eq("rst_first", bus.issue_first, 0);
      check_eq("rst_last", bus.issue_last, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      run_job(10, 3, 24, 1'b0);
      run_job(5, 5, 5, 1'b0);       // back-to-back with the previous job
      @(posedge clk);
      #1;
      run_err(5, 0);
      run_err(5, 6);

      rand_ready = 1'b1;
      run_job(20, 4, 68, 1'b0);
      rand_ready = 1'b0;
      @(posedge clk);
      #1;

      run_job(10, 3, 24, 1'b1);

      // Abort a job with reset part-way through RUN.
      expect_job(20, 4);
      start = 1'b1;
      len1  = 8'd20;
      len2  = 8'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_valid", bus.issue_valid, 0);
      check_eq("midrst_x1", bus.issue_x1_idx, 0);
      check_eq("midrst_first", bus.issue_first, 0);
      check_eq("midrst_done", done, 0);
      for (int l = 0; l < NF; l++) exp_q[l].delete();
      exp_done_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_job(10, 3, 24, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
